// File: rtl/cpu_controller_if.sv
// Control-bus bundle between the controller and its host/datapath: instruction
// load/start handshake in, datapath control strobes and immediates out.
interface cpu_controller_if #(
  parameter int IR_W = 16,
  parameter int RN_W = 3
);
  logic            s;
  logic            load;
  logic [IR_W-1:0] in;
  logic [RN_W-1:0] readnum;
  logic [RN_W-1:0] writenum;
  logic            write;
  logic [2:0]      vsel;
  logic            loada;
  logic            loadb;
  logic            asel;
  logic            bsel;
  logic            loadc;
  logic            loads;
  logic [1:0]      shift;
  logic [1:0]      ALUop;
  logic [IR_W-1:0] sximm8;
  logic [IR_W-1:0] sximm5;
  logic            w;

  modport master (
    output s, load, in,
    input  readnum, writenum, write, vsel, loada, loadb, asel, bsel,
           loadc, loads, shift, ALUop, sximm8, sximm5, w
  );

  modport slave (
    input  s, load, in,
    output readnum, writenum, write, vsel, loada, loadb, asel, bsel,
           loadc, loads, shift, ALUop, sximm8, sximm5, w
  );
endinterface

// File: rtl/cpu_controller.sv
// Simple RISC Machine control unit: instruction register, decoder and a Moore
// FSM that sequences the datapath strobes for MOV/ADD/CMP/AND/MVN.
module cpu_controller #(
  parameter int IR_W = 16,
  parameter int RN_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  cpu_controller_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_GET_A     = 3'd2,
    ST_GET_B     = 3'd3,
    ST_ALU       = 3'd4,
    ST_WRITE_REG = 3'd5,
    ST_WRITE_IMM = 3'd6
  } state_t;

  localparam logic [2:0] VSEL_C     = 3'b001;
  localparam logic [2:0] VSEL_IMM8  = 3'b011;

  function automatic logic [IR_W-1:0] sext8(input logic [7:0] v);
    sext8 = {{(IR_W-8){v[7]}}, v};
  endfunction

  function automatic logic [IR_W-1:0] sext5(input logic [4:0] v);
    sext5 = {{(IR_W-5){v[4]}}, v};
  endfunction

  state_t          state_r;
  state_t          next_state_s;
  logic [IR_W-1:0] ir_r;

  logic [2:0]      opcode_s;
  logic [1:0]      op_s;
  logic [RN_W-1:0] rn_s;
  logic [RN_W-1:0] rd_s;
  logic [RN_W-1:0] rm_s;
  logic            is_mov_imm_s;
  logic            is_mov_reg_s;
  logic            is_add_s;
  logic            is_cmp_s;
  logic            is_and_s;
  logic            is_mvn_s;

  logic [RN_W-1:0] readnum_s;
  logic [RN_W-1:0] writenum_s;
  logic            write_s;
  logic [2:0]      vsel_s;
  logic            loada_s;
  logic            loadb_s;
  logic            asel_s;
  logic            bsel_s;
  logic            loadc_s;
  logic            loads_s;
  logic [1:0]      aluop_s;

  assign opcode_s = ir_r[15:13];
  assign op_s     = ir_r[12:11];
  assign rn_s     = ir_r[10:8];
  assign rd_s     = ir_r[7:5];
  assign rm_s     = ir_r[2:0];

  assign is_mov_imm_s = (opcode_s == 3'b110) && (op_s == 2'b10);
  assign is_mov_reg_s = (opcode_s == 3'b110) && (op_s == 2'b00);
  assign is_add_s     = (opcode_s == 3'b101) && (op_s == 2'b00);
  assign is_cmp_s     = (opcode_s == 3'b101) && (op_s == 2'b01);
  assign is_and_s     = (opcode_s == 3'b101) && (op_s == 2'b10);
  assign is_mvn_s     = (opcode_s == 3'b101) && (op_s == 2'b11);

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_WAIT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Instruction register, writable only while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_r <= {IR_W{1'b0}};
    end else if (bus.load && (state_r == ST_WAIT)) begin
      ir_r <= bus.in;
    end else begin
      ir_r <= ir_r;
    end
  end

  // Next-state and Moore strobe decode.
  always_comb begin
    next_state_s = state_r;
    readnum_s    = {RN_W{1'b0}};
    writenum_s   = {RN_W{1'b0}};
    write_s      = 1'b0;
    vsel_s       = VSEL_C;
    loada_s      = 1'b0;
    loadb_s      = 1'b0;
    asel_s       = 1'b0;
    bsel_s       = 1'b0;
    loadc_s      = 1'b0;
    loads_s      = 1'b0;

    case (state_r)
      ST_WAIT: begin
        if (bus.s) begin
          next_state_s = ST_DECODE;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_DECODE: begin
        if (is_mov_imm_s) begin
          next_state_s = ST_WRITE_IMM;
        end else if (is_mov_reg_s || is_mvn_s) begin
          next_state_s = ST_GET_B;
        end else if (is_add_s || is_cmp_s || is_and_s) begin
          next_state_s = ST_GET_A;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_GET_A: begin
        readnum_s    = rn_s;
        loada_s      = 1'b1;
        next_state_s = ST_GET_B;
      end
      ST_GET_B: begin
        readnum_s    = rm_s;
        loadb_s      = 1'b1;
        next_state_s = ST_ALU;
      end
      ST_ALU: begin
        // Single-operand ops pass Rm through by zeroing the A side.
        if (is_mov_reg_s || is_mvn_s) begin
          asel_s = 1'b1;
        end else begin
          asel_s = 1'b0;
        end
        if (is_cmp_s) begin
          loads_s      = 1'b1;
          next_state_s = ST_WAIT;
        end else begin
          loadc_s      = 1'b1;
          next_state_s = ST_WRITE_REG;
        end
      end
      ST_WRITE_REG: begin
        writenum_s   = rd_s;
        vsel_s       = VSEL_C;
        write_s      = 1'b1;
        next_state_s = ST_WAIT;
      end
      ST_WRITE_IMM: begin
        writenum_s   = rn_s;
        vsel_s       = VSEL_IMM8;
        write_s      = 1'b1;
        next_state_s = ST_WAIT;
      end
      default: begin
        next_state_s = ST_WAIT;
      end
    endcase
  end

  // ALU op comes straight from the IR, except MOV-reg which is a plain pass.
  always_comb begin
    if (is_mov_reg_s) begin
      aluop_s = 2'b00;
    end else begin
      aluop_s = op_s;
    end
  end

  assign bus.readnum  = readnum_s;
  assign bus.writenum = writenum_s;
  assign bus.write    = write_s;
  assign bus.vsel     = vsel_s;
  assign bus.loada    = loada_s;
  assign bus.loadb    = loadb_s;
  assign bus.asel     = asel_s;
  assign bus.bsel     = bsel_s;
  assign bus.loadc    = loadc_s;
  assign bus.loads    = loads_s;
  assign bus.shift    = ir_r[4:3];
  assign bus.ALUop    = aluop_s;
  assign bus.sximm8   = sext8(ir_r[7:0]);
  assign bus.sximm5   = sext5(ir_r[4:0]);
  assign bus.w        = (state_r == ST_WAIT);

endmodule

// File: tb/tb_cpu_controller.sv
// Directed self-checking bench for cpu_controller: walks each instruction class
// state by state against hand-decoded expectations.
module tb_cpu_controller;

  logic clk;
  logic reset;
  int   check_cnt;
  int   fail_cnt;

  cpu_controller_if bus ();

  cpu_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    check_cnt = check_cnt + 1;
    if (obs !== exp) begin
      fail_cnt = fail_cnt + 1;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [15:0] val);
    bus.in   = val;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  // Edge 0: sample s=1 in WAIT, leaves the FSM in DECODE.
  task automatic start();
    bus.s = 1'b1;
    tick();
    bus.s = 1'b0;
  endtask

  initial begin
    check_cnt = 0;
    fail_cnt  = 0;
    reset     = 1'b1;
    bus.s     = 1'b0;
    bus.load  = 1'b0;
    bus.in    = 16'h0000;
    tick();
    tick();
    check_eq("rst_w",      {15'd0, bus.w},     16'h0001);
    check_eq("rst_write",  {15'd0, bus.write}, 16'h0000);
    check_eq("rst_vsel",   {13'd0, bus.vsel},  16'h0001);
    check_eq("rst_sximm8", bus.sximm8,         16'h0000);
    reset = 1'b0;
    tick();

    // MOV R0,#7
    load_ir(16'hD007);
    start();
    check_eq("movi_busy_w", {15'd0, bus.w}, 16'h0000);
    tick();
    check_eq("movi_writenum", {13'd0, bus.writenum}, 16'h0000);
    check_eq("movi_vsel",     {13'd0, bus.vsel},     16'h0003);
    check_eq("movi_write",    {15'd0, bus.write},    16'h0001);
    check_eq("movi_sximm8",   bus.sximm8,            16'h0007);
    tick();
    check_eq("movi_done_w",   {15'd0, bus.w},        16'h0001);
    check_eq("movi_done_wr",  {15'd0, bus.write},    16'h0000);

    // MOV R1,#-2
    load_ir(16'hD1FE);
    start();
    tick();
    check_eq("movn_sximm8",   bus.sximm8,            16'hFFFE);
    check_eq("movn_sximm5",   bus.sximm5,            16'hFFFE);
    check_eq("movn_writenum", {13'd0, bus.writenum}, 16'h0001);
    tick();
    check_eq("movn_done_w",   {15'd0, bus.w},        16'h0001);

    // ADD R2,R1,R0 LSL#1
    load_ir(16'hA148);
    start();
    check_eq("add_dec_loada", {15'd0, bus.loada},    16'h0000);
    tick();
    check_eq("add_ga_readnum", {13'd0, bus.readnum}, 16'h0001);
    check_eq("add_ga_loada",  {15'd0, bus.loada},    16'h0001);
    check_eq("add_ga_loadb",  {15'd0, bus.loadb},    16'h0000);
    tick();
    check_eq("add_gb_readnum", {13'd0, bus.readnum}, 16'h0000);
    check_eq("add_gb_loadb",  {15'd0, bus.loadb},    16'h0001);
    check_eq("add_gb_loada",  {15'd0, bus.loada},    16'h0000);
    tick();
    check_eq("add_alu_shift", {14'd0, bus.shift},    16'h0001);
    check_eq("add_alu_aluop", {14'd0, bus.ALUop},    16'h0000);
    check_eq("add_alu_asel",  {15'd0, bus.asel},     16'h0000);
    check_eq("add_alu_bsel",  {15'd0, bus.bsel},     16'h0000);
    check_eq("add_alu_loadc", {15'd0, bus.loadc},    16'h0001);
    check_eq("add_alu_write", {15'd0, bus.write},    16'h0000);
    tick();
    check_eq("add_wr_writenum", {13'd0, bus.writenum}, 16'h0002);
    check_eq("add_wr_write",  {15'd0, bus.write},    16'h0001);
    check_eq("add_wr_vsel",   {13'd0, bus.vsel},     16'h0001);
    check_eq("add_wr_w",      {15'd0, bus.w},        16'h0000);
    tick();
    check_eq("add_done_w",    {15'd0, bus.w},        16'h0001);

    // CMP R1,R0
    load_ir(16'hA900);
    start();
    tick();
    check_eq("cmp_ga_readnum", {13'd0, bus.readnum}, 16'h0001);
    check_eq("cmp_ga_write",  {15'd0, bus.write},    16'h0000);
    tick();
    check_eq("cmp_gb_write",  {15'd0, bus.write},    16'h0000);
    tick();
    check_eq("cmp_alu_loads", {15'd0, bus.loads},    16'h0001);
    check_eq("cmp_alu_loadc", {15'd0, bus.loadc},    16'h0000);
    check_eq("cmp_alu_aluop", {14'd0, bus.ALUop},    16'h0001);
    check_eq("cmp_alu_write", {15'd0, bus.write},    16'h0000);
    tick();
    check_eq("cmp_done_w",    {15'd0, bus.w},        16'h0001);
    check_eq("cmp_done_write", {15'd0, bus.write},   16'h0000);

    // MVN R3,R0: GET_A skipped
    load_ir(16'hB860);
    start();
    tick();
    check_eq("mvn_gb_loadb",  {15'd0, bus.loadb},    16'h0001);
    check_eq("mvn_gb_loada",  {15'd0, bus.loada},    16'h0000);
    tick();
    check_eq("mvn_alu_asel",  {15'd0, bus.asel},     16'h0001);
    check_eq("mvn_alu_aluop", {14'd0, bus.ALUop},    16'h0003);
    check_eq("mvn_alu_loadc", {15'd0, bus.loadc},    16'h0001);
    tick();
    check_eq("mvn_wr_writenum", {13'd0, bus.writenum}, 16'h0003);
    check_eq("mvn_wr_write",  {15'd0, bus.write},    16'h0001);
    tick();
    check_eq("mvn_done_w",    {15'd0, bus.w},        16'h0001);

    // Load while busy is ignored
    load_ir(16'hD007);
    start();
    bus.in   = 16'hFFFF;
    bus.load = 1'b1;
    tick();
    check_eq("busy_load_sx8", bus.sximm8,            16'h0007);
    tick();
    bus.load = 1'b0;
    check_eq("busy_load_w",   {15'd0, bus.w},        16'h0001);
    check_eq("busy_load_ir",  bus.sximm8,            16'h0007);

    // Undefined opcode: DECODE then straight back to WAIT
    load_ir(16'h0000);
    start();
    check_eq("undef_dec_w",   {15'd0, bus.w},        16'h0000);
    check_eq("undef_dec_strb", {10'd0, bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel}, 16'h0000);
    tick();
    check_eq("undef_done_w",  {15'd0, bus.w},        16'h0001);
    check_eq("undef_done_strb", {10'd0, bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel}, 16'h0000);

    // Reset mid-cycle while in GET_B
    load_ir(16'hA148);
    start();
    tick();
    tick();
    check_eq("rstgb_pre_loadb", {15'd0, bus.loadb},  16'h0001);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rstgb_w",       {15'd0, bus.w},        16'h0001);
    check_eq("rstgb_strb",    {10'd0, bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel}, 16'h0000);
    check_eq("rstgb_vsel",    {13'd0, bus.vsel},     16'h0001);
    check_eq("rstgb_readnum", {13'd0, bus.readnum},  16'h0000);
    check_eq("rstgb_ir",      bus.sximm8,            16'h0000);
    tick();
    reset = 1'b0;
    tick();
    check_eq("rstgb_after_w", {15'd0, bus.w},        16'h0001);

    // s held high re-runs the same IR after returning to WAIT
    load_ir(16'hD007);
    bus.s = 1'b1;
    tick();
    tick();
    check_eq("hold_wimm_write", {15'd0, bus.write},  16'h0001);
    tick();
    check_eq("hold_wait_w",   {15'd0, bus.w},        16'h0001);
    tick();
    check_eq("hold_redec_w",  {15'd0, bus.w},        16'h0000);
    bus.s = 1'b0;
    tick();
    check_eq("hold_rerun_write", {15'd0, bus.write}, 16'h0001);
    tick();
    check_eq("hold_final_w",  {15'd0, bus.w},        16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule
